fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//   Downstream consumer of fifo_clean: pops bytes from the 16x8 FIFO and sends each as an
//   async serial frame on tx (start, DATA_W bits LSB-first, optional even parity, stop).
//   Drives the FIFO read_en and consumes its data_out and empty. Back-to-back frames
//   are sent while the FIFO is non-empty.
// PARAMETERS
//   DATA_W       8   frame payload width; must match FIFO data width
//   CLKS_PER_BIT 16  clk cycles per serial bit, >=2
//   PARITY_EN    0   1: append even-parity bit after data
//   STOP_BITS    1   number of stop bits, 1 or 2
// PORTS
//   clk          in   1       system clock, rising edge
//   rst          in   1       synchronous, active-low reset
//   fifo_empty   in   1       FIFO empty flag
//   fifo_data    in   DATA_W  FIFO data_out, valid the cycle after read_en is sampled
//   fifo_read_en out  1       one-cycle pop request to FIFO read_en
//   tx           out  1       serial line, idle high
//   busy         out  1       high from FETCH through last stop-bit cycle
//   frame_done   out  1       one-cycle pulse in last cycle of the final stop bit
// BEHAVIOUR
//   Reset (rst==0 at posedge): state=IDLE, tx=1, busy=0, fifo_read_en=0, frame_done=0,
//     counters cleared. All outputs are registered.
//   States: IDLE -> FETCH -> LOAD -> START -> DATA -> [PARITY] -> STOP -> FETCH | IDLE.
//   IDLE: tx=1. If fifo_empty==0, go to FETCH next edge; otherwise stay.
//   FETCH: fifo_read_en=1 for exactly one cycle; busy=1. Go to LOAD.
//   LOAD: shift_reg <= fifo_data; parity <= ^fifo_data. tx stays 1. Go to START.
//   START: tx=0 for CLKS_PER_BIT cycles.
//   DATA: tx=shift_reg[0] for CLKS_PER_BIT cycles per bit, shift right; DATA_W bits.
//   PARITY (PARITY_EN=1 only): tx=^data (even parity) for CLKS_PER_BIT cycles.
//   STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; frame_done=1 in the final cycle.
//     After the final cycle: if fifo_empty==0 go to FETCH (busy stays 1), else go to IDLE.
//   Frame length (START..STOP end) = (1+DATA_W+PARITY_EN+STOP_BITS)*CLKS_PER_BIT.
//   Inter-frame gap with back-to-back data: exactly 2 tx-high cycles (FETCH, LOAD).
//   Baud counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). Bit index counts
//     0..DATA_W-1. Both reload at each bit boundary.
//   fifo_read_en is never asserted when fifo_empty==1, and is asserted only in FETCH.
//     fifo_empty is ignored in every other state.
//   Reset mid-frame aborts the frame: tx=1 at that edge and the byte is lost. No pop
//     occurs while rst==0. After release, the next frame starts cleanly from IDLE.
//   fifo_data is sampled only in LOAD. Later FIFO writes do not disturb the frame in flight.
// TESTING
//   1 Reset: rst=0 for 2 cycles with fifo_empty=0 -> tx=1, busy=0, fifo_read_en=0 throughout.
//   2 Single byte 0xA5, CLKS_PER_BIT=16, PARITY_EN=0, STOP_BITS=1 -> one read pulse; tx low
//     16 cycles starting 2 cycles after the pulse; bits 1,0,1,0,0,1,0,1; 16 stop cycles;
//     frame_done once; 160-cycle frame; then IDLE with busy=0.
//   3 Pre-fill FIFO with 16 random bytes, then stream -> exactly 16 read pulses; frames match
//     write order; 2-cycle gaps between frames; IDLE once empty; no read while empty.
//   4 PARITY_EN=1, byte 0x07 -> parity bit 1; byte 0x03 -> parity bit 0; frame 176 cycles.
//   5 rst=0 during DATA bit 3 of 0x5A -> tx=1 next edge, busy=0, no read pulse while in reset;
//     after release, the next queued byte is sent correctly.
//   6 STOP_BITS=2, byte 0xFF -> tx high for 32 stop cycles; frame_done only in the last one.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx_if
// Read-side connection between a byte FIFO and the serial transmitter that
// drains it.
//   fifo_empty   FIFO empty flag (FIFO -> transmitter)
//   fifo_data    FIFO data_out, valid the cycle after fifo_read_en is sampled
//   fifo_read_en one-cycle pop request (transmitter -> FIFO)
// Modports:
//   master  transmitter side, which issues pops
//   slave   FIFO side, which answers them
// ---------------------------------------------------------------------------
interface fifo_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_read_en;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_read_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_read_en
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Pops bytes from a FIFO and sends each one as an asynchronous serial frame:
// a start bit, DATA_W data bits LSB first, an optional even-parity bit, and
// STOP_BITS stop bits. Frames follow each other back to back while the FIFO
// still holds data. Between frames the line stays high for exactly two
// cycles, which are the FETCH and LOAD states.
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   io_fifo      FIFO read interface (master modport)
//   o_tx         serial line, idle high
//   o_busy       high from FETCH through the last stop-bit cycle
//   o_frame_done one-cycle pulse in the last cycle of the final stop bit
// Every output comes from a register. The next-state logic works out each
// output's value for the coming state, so the output always lines up with
// the state that is current.
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_uart_tx_if.master        io_fifo,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              r_state;
  logic [BAUD_W-1:0]   r_baudCnt;
  logic [IDX_W-1:0]    r_bitIdx;
  logic [DATA_W-1:0]   r_shift;
  logic                r_parity;
  logic                r_tx;
  logic                r_busy;
  logic                r_frameDone;
  logic                r_readEn;

  state_t              w_stateNext;
  logic [BAUD_W-1:0]   w_baudNext;
  logic [IDX_W-1:0]    w_bitIdxNext;
  logic [DATA_W-1:0]   w_shiftNext;
  logic                w_parityNext;
  logic                w_txNext;
  logic                w_busyNext;
  logic                w_frameDoneNext;
  logic                w_readEnNext;
  logic                w_bitEnd;

  assign w_bitEnd             = (r_baudCnt == BAUD_LAST);
  assign o_tx                 = r_tx;
  assign o_busy               = r_busy;
  assign o_frame_done         = r_frameDone;
  assign io_fifo.fifo_read_en = r_readEn;

  // State register and registered outputs. A reset in the middle of a frame
  // drops the frame and brings the line high at that same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_baudCnt   <= '0;
      r_bitIdx    <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
      r_readEn    <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_baudCnt   <= w_baudNext;
      r_bitIdx    <= w_bitIdxNext;
      r_shift     <= w_shiftNext;
      r_parity    <= w_parityNext;
      r_tx        <= w_txNext;
      r_busy      <= w_busyNext;
      r_frameDone <= w_frameDoneNext;
      r_readEn    <= w_readEnNext;
    end
  end

  // Next-state and next-output logic. The baud counter and the bit index
  // both restart at every bit boundary. In STOP the bit index counts stop
  // bits. fifo_empty is read only when deciding whether to fetch, so a pop
  // is only requested after the FIFO has shown data. fifo_data is captured
  // only in LOAD, so later FIFO writes do not touch the frame being sent.
  always_comb begin
    w_stateNext  = r_state;
    w_baudNext   = r_baudCnt;
    w_bitIdxNext = r_bitIdx;
    w_shiftNext  = r_shift;
    w_parityNext = r_parity;

    case (r_state)
      S_IDLE: begin
        w_baudNext   = '0;
        w_bitIdxNext = '0;
        if (!io_fifo.fifo_empty) w_stateNext = S_FETCH;
      end
      S_FETCH: begin
        w_stateNext = S_LOAD;
      end
      S_LOAD: begin
        w_shiftNext  = io_fifo.fifo_data;
        w_parityNext = ^io_fifo.fifo_data;
        w_baudNext   = '0;
        w_bitIdxNext = '0;
        w_stateNext  = S_START;
      end
      S_START: begin
        if (w_bitEnd) begin
          w_baudNext   = '0;
          w_bitIdxNext = '0;
          w_stateNext  = S_DATA;
        end else begin
          w_baudNext = r_baudCnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bitEnd) begin
          w_baudNext  = '0;
          w_shiftNext = r_shift >> 1;
          if (r_bitIdx == DATA_LAST) begin
            w_bitIdxNext = '0;
            w_stateNext  = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bitIdxNext = r_bitIdx + 1'b1;
          end
        end else begin
          w_baudNext = r_baudCnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (w_bitEnd) begin
          w_baudNext   = '0;
          w_bitIdxNext = '0;
          w_stateNext  = S_STOP;
        end else begin
          w_baudNext = r_baudCnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_bitEnd) begin
          w_baudNext = '0;
          if (r_bitIdx == STOP_LAST) begin
            w_bitIdxNext = '0;
            w_stateNext  = io_fifo.fifo_empty ? S_IDLE : S_FETCH;
          end else begin
            w_bitIdxNext = r_bitIdx + 1'b1;
          end
        end else begin
          w_baudNext = r_baudCnt + 1'b1;
        end
      end
      default: begin
        w_stateNext  = S_IDLE;
        w_baudNext   = '0;
        w_bitIdxNext = '0;
      end
    endcase

    // The outputs are computed from the state being entered, so each
    // registered output matches the state during the same cycle.
    w_txNext = 1'b1;
    case (w_stateNext)
      S_START:  w_txNext = 1'b0;
      S_DATA:   w_txNext = w_shiftNext[0];
      S_PARITY: w_txNext = w_parityNext;
      default:  w_txNext = 1'b1;
    endcase

    w_busyNext      = (w_stateNext != S_IDLE);
    w_readEnNext    = (w_stateNext == S_FETCH);
    w_frameDoneNext = (w_stateNext == S_STOP) && (w_baudNext == BAUD_LAST) &&
                      (w_bitIdxNext == STOP_LAST);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
// Drives three transmitters that differ in configuration from a single FIFO
// model:
//   dut0  no parity, one stop bit
//   dut1  even parity, one stop bit
//   dut2  no parity, two stop bits
// Only the selected transmitter sees the FIFO. The others see an empty FIFO
// and must stay idle.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst;
  logic wrReq;
  logic [7:0] wrData;
  int sel;

  logic [7:0] q[$];
  logic mEmpty = 1'b1;
  logic [7:0] mData = 8'h00;

  int nChecks = 0;
  int nFails = 0;
  int pulseCnt = 0;
  int rdEmptyViol = 0;

  int frWait, frTimeout, frGlitch, frDoneCnt, frDoneAt, frReadPulses, frBusyLow;
  logic frFetchTx, frLoadTx;
  logic [15:0] frBits;

  logic tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;
  wire [2:0] txV     = {tx2, tx1, tx0};
  wire [2:0] busyV   = {busy2, busy1, busy0};
  wire [2:0] doneV   = {done2, done1, done0};
  wire [2:0] readEnV;
  wire [2:0] emptyV;

  fifo_uart_tx_if #(.DATA_W(8)) ifc0 ();
  fifo_uart_tx_if #(.DATA_W(8)) ifc1 ();
  fifo_uart_tx_if #(.DATA_W(8)) ifc2 ();

  assign ifc0.fifo_empty = (sel == 0) ? mEmpty : 1'b1;
  assign ifc1.fifo_empty = (sel == 1) ? mEmpty : 1'b1;
  assign ifc2.fifo_empty = (sel == 2) ? mEmpty : 1'b1;
  assign ifc0.fifo_data  = mData;
  assign ifc1.fifo_data  = mData;
  assign ifc2.fifo_data  = mData;
  assign readEnV = {ifc2.fifo_read_en, ifc1.fifo_read_en, ifc0.fifo_read_en};
  assign emptyV  = {ifc2.fifo_empty, ifc1.fifo_empty, ifc0.fifo_empty};

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .io_fifo(ifc0),
    .o_tx(tx0), .o_busy(busy0), .o_frame_done(done0));
  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .io_fifo(ifc1),
    .o_tx(tx1), .o_busy(busy1), .o_frame_done(done1));
  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .io_fifo(ifc2),
    .o_tx(tx2), .o_busy(busy2), .o_frame_done(done2));

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // FIFO model: a pop hands out data the cycle after read_en, and the empty
  // flag follows the contents once the edge's push and pop are both done
  always @(posedge clk) begin
    if (readEnV[sel] === 1'b1 && q.size() > 0) mData <= q.pop_front();
    if (wrReq) q.push_back(wrData);
    mEmpty <= (q.size() == 0);
  end

  // Counts pops from the selected transmitter, and any pop made while its
  // FIFO looks empty
  always @(negedge clk) begin
    if (readEnV[sel] === 1'b1) pulseCnt++;
    for (int i = 0; i < 3; i++)
      if (readEnV[i] === 1'b1 && emptyV[i] === 1'b1) rdEmptyViol++;
  end

  // Stops a run that hangs
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [15:0] expBits;
    int         nBits;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] streamBytes[16];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Pushes one byte into the FIFO model; call at a negedge, returns at the next
  task automatic applyStimulus(input logic [7:0] b);
    wrData = b;
    wrReq  = 1'b1;
    @(negedge clk);
    wrReq  = 1'b0;
  endtask

  // Waits for a pop, then records one frame. t=0 is FETCH and t=1 is LOAD.
  // Serial bit k spans t = 2+16k .. 17+16k.
  task automatic watchFrame(input int s, input int nBits);
    int idx;
    int pos;
    frWait = 0; frTimeout = 0; frGlitch = 0; frDoneCnt = 0; frDoneAt = -1;
    frReadPulses = 0; frBusyLow = 0; frBits = '0; frFetchTx = 1'bx; frLoadTx = 1'bx;
    while (readEnV[s] !== 1'b1) begin
      if (frWait >= 300) begin
        frTimeout = 1;
        return;
      end
      @(negedge clk);
      frWait++;
    end
    frFetchTx = txV[s];
    for (int t = 1; t <= 1 + nBits * CPB; t++) begin
      @(negedge clk);
      if (t == 1) frLoadTx = txV[s];
      else begin
        idx = (t - 2) / CPB;
        pos = (t - 2) % CPB;
        if (pos == 0) frBits[idx] = txV[s];
        else if (txV[s] !== frBits[idx]) frGlitch++;
      end
      if (doneV[s] === 1'b1) begin
        frDoneCnt++;
        frDoneAt = t;
      end
      if (readEnV[s] === 1'b1) frReadPulses++;
      if (busyV[s] !== 1'b1) frBusyLow++;
    end
  endtask

  task automatic checkFrame(input logic [15:0] expBits, input int nBits);
    checkOutput("frameTimeout", frTimeout, 0);
    checkOutput("frameBits", frBits, expBits);
    checkOutput("frameGlitch", frGlitch, 0);
    checkOutput("frameDoneCount", frDoneCnt, 1);
    checkOutput("frameDoneAt", frDoneAt, 1 + nBits * CPB);
    checkOutput("frameExtraReads", frReadPulses, 0);
    checkOutput("frameBusyLow", frBusyLow, 0);
    checkOutput("fetchTxHigh", frFetchTx, 1);
    checkOutput("loadTxHigh", frLoadTx, 1);
  endtask

  task automatic checkIdle(input int s);
    checkOutput("idleBusy", busyV[s], 0);
    checkOutput("idleTx", txV[s], 1);
    checkOutput("idleReadEn", readEnV[s], 0);
  endtask

  initial begin
    int resetViol;
    int pc;
    int w;
    rst = 1'b0; wrReq = 1'b0; wrData = 8'h00; sel = 0;

    // Frames are listed LSB first: bit0 is the start bit, then the data
    // bits, then parity (if used), then the stop bits
    vecs[0] = '{0, 8'hA5, 16'h034A, 10};
    vecs[1] = '{0, 8'h00, 16'h0200, 10};
    vecs[2] = '{0, 8'hFF, 16'h03FE, 10};
    vecs[3] = '{1, 8'h07, 16'h060E, 11};
    vecs[4] = '{1, 8'h03, 16'h0406, 11};
    vecs[5] = '{1, 8'h80, 16'h0700, 11};
    vecs[6] = '{2, 8'hFF, 16'h07FE, 11};
    vecs[7] = '{2, 8'h5A, 16'h06B4, 11};

    @(negedge clk);

    // Reset held while the FIFO is pre-filled, so fifo_empty is low during it
    resetViol = 0;
    for (int i = 0; i < 16; i++) begin
      streamBytes[i] = 8'($urandom_range(0, 255));
      applyStimulus(streamBytes[i]);
      if (txV !== 3'b111 || busyV !== 3'b000 || readEnV !== 3'b000 || doneV !== 3'b000)
        resetViol++;
    end
    checkOutput("resetHoldOutputs", resetViol, 0);
    checkOutput("resetTx", txV[0], 1);
    checkOutput("resetBusy", busyV[0], 0);
    checkOutput("resetReadEn", readEnV[0], 0);
    checkOutput("resetNoPop", pulseCnt, 0);

    // Stream the 16 queued bytes back to back
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      watchFrame(0, 10);
      checkFrame(16'h0200 | (16'(streamBytes[i]) << 1), 10);
      if (i > 0) checkOutput("streamGap", frWait, 1);
    end
    @(negedge clk);
    checkIdle(0);
    repeat (5) @(negedge clk);
    checkOutput("streamPulses", pulseCnt, 16);
    checkOutput("readWhileEmpty", rdEmptyViol, 0);

    // Single bytes on each configuration, from the table
    for (int v = 0; v < 8; v++) begin
      sel = vecs[v].sel;
      applyStimulus(vecs[v].data);
      watchFrame(vecs[v].sel, vecs[v].nBits);
      checkFrame(vecs[v].expBits, vecs[v].nBits);
      @(negedge clk);
      checkIdle(vecs[v].sel);
    end

    // Reset in the middle of data bit 3 of 0x5A, with 0x3C still queued
    sel = 0;
    applyStimulus(8'h5A);
    applyStimulus(8'h3C);
    w = 0;
    while (readEnV[0] !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    checkOutput("abortReadSeen", readEnV[0], 1);
    repeat (60) @(negedge clk);
    checkOutput("abortBit2Low", txV[0], 0);
    repeat (11) @(negedge clk);
    checkOutput("abortBit3High", txV[0], 1);
    checkOutput("abortBusyBefore", busyV[0], 1);
    rst = 1'b0;
    pc = pulseCnt;
    @(negedge clk);
    checkOutput("abortTx", txV[0], 1);
    checkOutput("abortBusy", busyV[0], 0);
    checkOutput("abortDone", doneV[0], 0);
    repeat (3) @(negedge clk);
    checkOutput("abortNoPopInReset", pulseCnt, pc);
    rst = 1'b1;
    watchFrame(0, 10);
    checkFrame(16'h0278, 10);
    @(negedge clk);
    checkIdle(0);
    checkOutput("finalReadWhileEmpty", rdEmptyViol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
